// File: rtl/clock_group_reset_aggregator_if.sv
// Request/cause/reset bundle between the aggregator and its clock-group sinks.
// The master drives the requests and the cause clear; the slave (aggregator) drives the resets.
interface clock_group_reset_aggregator_if #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2
);
  logic [N_IN-1:0]  auto_in_reset;
  logic             cause_clear;
  logic [N_OUT-1:0] auto_out_reset;
  logic             busy;
  logic [N_IN-1:0]  cause;

  modport master (
    output auto_in_reset, cause_clear,
    input  auto_out_reset, busy, cause
  );

  modport slave (
    input  auto_in_reset, cause_clear,
    output auto_out_reset, busy, cause
  );
endinterface

// File: rtl/clock_group_reset_aggregator.sv
// Merges reset requests from a clock group into staggered, stretched per-sink resets,
// and keeps a sticky record of which requesters fired.
module clock_group_reset_aggregator #(
  parameter int N_IN    = 2,
  parameter int N_OUT   = 2,
  parameter int STRETCH = 16,
  parameter int GAP     = 4,
  parameter int CNT_W   = 8
) (
  input logic                           clock,
  input logic                           reset,
  clock_group_reset_aggregator_if.slave bus
);
  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_OUT - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX    = IDX_W'(1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [N_OUT-1:0] out_reg, out_next;
  logic             busy_reg;
  logic [N_IN-1:0]  cause_reg, cause_next;
  logic [N_IN-1:0]  in_q_reg;
  logic [N_OUT-1:0] release_hit;
  logic             any_req;

  assign any_req = |in_q_reg;

  // One-hot mask of the sink whose turn it is to leave reset.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_release
    assign release_hit[gi] = (idx_reg == IDX_W'(gi));
  end

  // Set wins over clear for any bit requested in the same cycle.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_cause
    assign cause_next[gi] = (cause_reg[gi] & ~bus.cause_clear) | in_q_reg[gi];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    out_next   = out_reg;
    case (state_reg)
      HOLD: begin
        out_next = '1;
        if (any_req) begin
          cnt_next = STRETCH_LOAD;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          out_next[0] = 1'b0;
          cnt_next    = GAP_LOAD;
          idx_next    = FIRST_IDX;
          state_next  = (N_OUT == 1) ? RUN : RELEASE;
        end
      end
      RELEASE: begin
        if (any_req) begin
          // Abort: sinks already released go back into reset.
          out_next   = '1;
          cnt_next   = STRETCH_LOAD;
          state_next = HOLD;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          out_next = out_reg & ~release_hit;
          cnt_next = GAP_LOAD;
          if (idx_reg == LAST_IDX) begin
            state_next = RUN;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      RUN: begin
        out_next = '0;
        if (any_req) begin
          out_next   = '1;
          cnt_next   = STRETCH_LOAD;
          state_next = HOLD;
        end
      end
      default: begin
        out_next   = '1;
        cnt_next   = STRETCH_LOAD;
        state_next = HOLD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= HOLD;
      cnt_reg   <= STRETCH_LOAD;
      idx_reg   <= '0;
      out_reg   <= '1;
      busy_reg  <= 1'b1;
      cause_reg <= '0;
      in_q_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      out_reg   <= out_next;
      busy_reg  <= (state_next != RUN);
      cause_reg <= cause_next;
      in_q_reg  <= bus.auto_in_reset;
    end
  end

  assign bus.auto_out_reset = out_reg;
  assign bus.busy           = busy_reg;
  assign bus.cause          = cause_reg;
endmodule

// File: tb/tb_clock_group_reset_aggregator.sv
// Directed bench: default configuration (2 in, 2 out, stretch 16, gap 4) plus a
// single-output, stretch-1 instance sharing clock and reset.
module tb_clock_group_reset_aggregator;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  clock_group_reset_aggregator_if #(.N_IN(2), .N_OUT(2)) a_if ();
  clock_group_reset_aggregator_if #(.N_IN(2), .N_OUT(1)) b_if ();

  clock_group_reset_aggregator #(
    .N_IN(2), .N_OUT(2), .STRETCH(16), .GAP(4), .CNT_W(8)
  ) dut_a (
    .clock(clk),
    .reset(rst),
    .bus  (a_if)
  );

  clock_group_reset_aggregator #(
    .N_IN(2), .N_OUT(1), .STRETCH(1), .GAP(4), .CNT_W(8)
  ) dut_b (
    .clock(clk),
    .reset(rst),
    .bus  (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a_if.auto_in_reset = 2'b00;
    a_if.cause_clear   = 1'b0;
    b_if.auto_in_reset = 2'b00;
    b_if.cause_clear   = 1'b0;

    // Power-on
    tick(3);
    chk("por_out",   8'(a_if.auto_out_reset), 8'h3);
    chk("por_busy",  8'(a_if.busy),           8'h1);
    chk("por_cause", 8'(a_if.cause),          8'h0);
    chk("por_b_out", 8'(b_if.auto_out_reset), 8'h1);
    rst = 1'b0;
    tick(1);
    chk("b_por_out",  8'(b_if.auto_out_reset), 8'h0);
    chk("b_por_busy", 8'(b_if.busy),           8'h0);
    chk("por_e1_out", 8'(a_if.auto_out_reset), 8'h3);
    tick(14);
    chk("por_e15_out", 8'(a_if.auto_out_reset), 8'h3);
    tick(1);
    chk("por_e16_out",  8'(a_if.auto_out_reset), 8'h2);
    chk("por_e16_busy", 8'(a_if.busy),           8'h1);
    tick(3);
    chk("por_e19_out", 8'(a_if.auto_out_reset), 8'h2);
    tick(1);
    chk("por_e20_out",   8'(a_if.auto_out_reset), 8'h0);
    chk("por_e20_busy",  8'(a_if.busy),           8'h0);
    chk("por_e20_cause", 8'(a_if.cause),          8'h0);

    // Request pulse on in[1] while running
    a_if.auto_in_reset = 2'b10;
    tick(1);
    chk("req1_sample_out", 8'(a_if.auto_out_reset), 8'h0);
    a_if.auto_in_reset = 2'b00;
    tick(1);
    chk("req1_out",   8'(a_if.auto_out_reset), 8'h3);
    chk("req1_busy",  8'(a_if.busy),           8'h1);
    chk("req1_cause", 8'(a_if.cause),          8'h2);
    tick(15);
    chk("req1_e15_out", 8'(a_if.auto_out_reset), 8'h3);
    tick(1);
    chk("req1_e16_out", 8'(a_if.auto_out_reset), 8'h2);
    tick(4);
    chk("req1_e20_out",  8'(a_if.auto_out_reset), 8'h0);
    chk("req1_e20_busy", 8'(a_if.busy),           8'h0);

    // Re-request during HOLD restarts the stretch
    a_if.auto_in_reset = 2'b01;
    tick(1);
    a_if.auto_in_reset = 2'b00;
    tick(1);
    chk("hold_enter_out", 8'(a_if.auto_out_reset), 8'h3);
    chk("hold_cause",     8'(a_if.cause),          8'h3);
    tick(10);
    a_if.auto_in_reset = 2'b01;
    tick(1);
    a_if.auto_in_reset = 2'b00;
    tick(1);
    tick(15);
    chk("hold_restart_e15_out", 8'(a_if.auto_out_reset), 8'h3);
    tick(1);
    chk("hold_restart_e16_out", 8'(a_if.auto_out_reset), 8'h2);

    // Abort in RELEASE between out[0] and out[1]
    a_if.auto_in_reset = 2'b01;
    tick(1);
    chk("abort_sample_out", 8'(a_if.auto_out_reset), 8'h2);
    a_if.auto_in_reset = 2'b00;
    tick(1);
    chk("abort_out",  8'(a_if.auto_out_reset), 8'h3);
    chk("abort_busy", 8'(a_if.busy),           8'h1);
    tick(15);
    chk("abort_e15_out", 8'(a_if.auto_out_reset), 8'h3);
    tick(1);
    chk("abort_e16_out", 8'(a_if.auto_out_reset), 8'h2);
    tick(3);
    chk("abort_e19_out", 8'(a_if.auto_out_reset), 8'h2);
    tick(1);
    chk("abort_e20_out", 8'(a_if.auto_out_reset), 8'h0);

    // Cause clear racing a set: set wins on its own bit
    chk("clr_pre_cause", 8'(a_if.cause), 8'h3);
    a_if.auto_in_reset = 2'b01;
    tick(1);
    a_if.auto_in_reset = 2'b00;
    a_if.cause_clear   = 1'b1;
    tick(1);
    chk("clr_race_cause", 8'(a_if.cause), 8'h1);
    tick(1);
    chk("clr_idle_cause", 8'(a_if.cause), 8'h0);
    a_if.cause_clear = 1'b0;
    tick(20);
    chk("clr_settle_out",  8'(a_if.auto_out_reset), 8'h0);
    chk("clr_settle_busy", 8'(a_if.busy),           8'h0);

    // Block reset mid-RELEASE restarts the whole sequence
    a_if.auto_in_reset = 2'b10;
    tick(1);
    a_if.auto_in_reset = 2'b00;
    tick(1);
    tick(16);
    chk("rstmid_pre_out", 8'(a_if.auto_out_reset), 8'h2);
    rst = 1'b1;
    tick(1);
    chk("rstmid_out",   8'(a_if.auto_out_reset), 8'h3);
    chk("rstmid_busy",  8'(a_if.busy),           8'h1);
    chk("rstmid_cause", 8'(a_if.cause),          8'h0);
    rst = 1'b0;
    tick(15);
    chk("rstmid_e15_out", 8'(a_if.auto_out_reset), 8'h3);
    tick(1);
    chk("rstmid_e16_out", 8'(a_if.auto_out_reset), 8'h2);
    tick(4);
    chk("rstmid_e20_out", 8'(a_if.auto_out_reset), 8'h0);

    // Single output, stretch 1
    b_if.auto_in_reset = 2'b01;
    tick(1);
    chk("b_sample_out", 8'(b_if.auto_out_reset), 8'h0);
    b_if.auto_in_reset = 2'b00;
    tick(1);
    chk("b_assert_out",  8'(b_if.auto_out_reset), 8'h1);
    chk("b_assert_busy", 8'(b_if.busy),           8'h1);
    chk("b_cause",       8'(b_if.cause),          8'h1);
    tick(1);
    chk("b_release_out",  8'(b_if.auto_out_reset), 8'h0);
    chk("b_release_busy", 8'(b_if.busy),           8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
